// File: rtl/int_alu_pkg.sv
// Shared Int_ALU definitions: multiplier widths and the arbiter FSM state encoding.
package int_alu_pkg;

    localparam int MUL_W      = 4;
    localparam int MUL_FULL_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } mul_arb_state_t;

endpackage

// File: rtl/mul_arb_pick.sv
// Combinational one-hot picker: first valid request found searching upward
// from ptr_i with wrap-around. ptr_i = 0 gives plain lowest-index priority.
module mul_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               any_o
);

    always_comb begin
        int              pos;
        logic [ID_W-1:0] idx;
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr_i) + k) % NUM_REQ;
            idx = ID_W'(pos);
            if (!any_o && req_valid_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_4bit_carry.sv
// Int_ALU 4-bit multiplier: full = a*b + carry_in; product is the low nibble,
// carry_out flags any bit set in the high nibble.
module multiplier_4bit_carry
    import int_alu_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             carry_in,
    output logic [MUL_W-1:0] product,
    output logic             carry_out
);

    logic [MUL_FULL_W-1:0] full;

    assign full      = MUL_FULL_W'(a) * MUL_FULL_W'(b) + MUL_FULL_W'(carry_in);
    assign product   = full[MUL_W-1:0];
    assign carry_out = |full[MUL_FULL_W-1:MUL_W];

endmodule

// File: rtl/mul_share_arbiter.sv
// Arbitrated front end sharing one multiplier_4bit_carry among NUM_REQ requesters.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mul_share_arbiter
    import int_alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [MUL_W*NUM_REQ-1:0] req_a,
    input  logic [MUL_W*NUM_REQ-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [MUL_W-1:0]         rsp_product,
    output logic                     rsp_carry_out,
    output logic                     busy
);

    mul_arb_state_t state_q, state_d;

    logic [MUL_W-1:0]   op_a_q, op_b_q;
    logic               op_cin_q;
    logic [ID_W-1:0]    op_id_q;
    logic [MUL_W-1:0]   res_prod_q;
    logic               res_co_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_valid_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [ID_W-1:0]    ptr;
    logic               accept;
    logic               consume;
    logic [MUL_W-1:0]   mul_prod;
    logic               mul_co;

    mul_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .any_o       (gnt_any)
    );

`ifdef MUL_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    multiplier_4bit_carry u_mul (
        .a         (op_a_q),
        .b         (op_b_q),
        .carry_in  (op_cin_q),
        .product   (mul_prod),
        .carry_out (mul_co)
    );

    // Grant is visible only in IDLE and is forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE) begin
            req_ready = gnt;
        end
        accept  = (state_q == IDLE) && gnt_any;
        consume = (state_q == RESP) && rsp_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (consume) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            res_prod_q  <= '0;
            res_co_q    <= 1'b0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == RESP);
            busy_q      <= (state_d != IDLE);
            if (accept) begin
                op_a_q   <= req_a[MUL_W*int'(gnt_id) +: MUL_W];
                op_b_q   <= req_b[MUL_W*int'(gnt_id) +: MUL_W];
                op_cin_q <= req_cin[gnt_id];
                op_id_q  <= gnt_id;
            end
            if (state_q == EXEC) begin
                res_prod_q <= mul_prod;
                res_co_q   <= mul_co;
                rsp_id_q   <= op_id_q;
            end
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_product   = res_prod_q;
    assign rsp_carry_out = res_co_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; expectations follow the build's MUL_ARB_RR_EN setting.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [3:0]           rsp_product;
    logic                 rsp_carry_out;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cin       (req_cin),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_product   (rsp_product),
        .rsp_carry_out (rsp_carry_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_product"}, rsp_product, 0);
        check({tag, "_carry"}, rsp_carry_out, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    // Single request from requester idx; optional hold of rsp_ready low in RESP.
    task automatic run_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic [3:0] ep, input logic eco,
                           input int hold);
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        req_a[idx*4 +: 4] = a;
        req_b[idx*4 +: 4] = b;
        req_cin[idx] = cin;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        check($sformatf("r%0d_ready", idx), req_ready, 32'(1 << idx));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check($sformatf("r%0d_exec_valid", idx), rsp_valid, 0);
        check($sformatf("r%0d_exec_busy", idx), busy, 1);
        @(negedge clk);
        check($sformatf("r%0d_rsp_valid", idx), rsp_valid, 1);
        check($sformatf("r%0d_product", idx), rsp_product, ep);
        check($sformatf("r%0d_carry", idx), rsp_carry_out, eco);
        check($sformatf("r%0d_id", idx), rsp_id, idx);
        for (int h = 0; h < hold; h++) begin
            req_valid = '1;
            @(negedge clk);
            check($sformatf("hold%0d_valid", h), rsp_valid, 1);
            check($sformatf("hold%0d_product", h), rsp_product, ep);
            check($sformatf("hold%0d_carry", h), rsp_carry_out, eco);
            check($sformatf("hold%0d_id", h), rsp_id, idx);
            check($sformatf("hold%0d_req_ready", h), req_ready, 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check($sformatf("r%0d_done_valid", idx), rsp_valid, 0);
        check($sformatf("r%0d_done_busy", idx), busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[5];
        int gcyc[5];
        int ngr;
        int exp_id;
        int waited;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        run_req(0, 4'd2,  4'd1, 1'b0, 4'b0010, 1'b0, 0);
        run_req(1, 4'd3,  4'd2, 1'b0, 4'b0110, 1'b0, 0);
        run_req(2, 4'd1,  4'd7, 1'b1, 4'b1000, 1'b0, 0);
        run_req(3, 4'd11, 4'd3, 1'b0, 4'b0001, 1'b1, 4);

        // All requesters continuously valid with rsp_ready high.
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1);
            req_b[i*4 +: 4] = 4'd2;
        end
        req_cin   = '0;
        rsp_ready = 1'b1;
        req_valid = '1;
        ngr = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready != 0 && ngr < 5) begin
                gid[ngr]  = oh_idx(req_ready);
                gcyc[ngr] = c;
                ngr++;
            end
        end
        req_valid = '0;
        check("stream_grant_count", ngr, 5);
        for (int k = 0; k < 5; k++) begin
`ifdef MUL_ARB_RR_EN
            exp_id = k % NUM_REQ;
`else
            exp_id = 0;
`endif
            check($sformatf("stream_gid%0d", k), gid[k], exp_id);
            if (k > 0) check($sformatf("stream_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        waited = 0;
        while (busy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("stream_drain_busy", busy, 0);

        // Abort an operation in EXEC with reset.
        @(posedge clk); #1;
        req_a[8 +: 4] = 4'd9;
        req_b[8 +: 4] = 4'd9;
        req_cin[2]    = 1'b0;
        req_valid     = 4'b0100;
        @(negedge clk);
        check("abort_ready", req_ready, 4'b0100);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_rsp%0d", c), rsp_valid, 0);
        end

        // Fresh request after reset: 1 and 3 valid, pointer back at 0 picks 1.
        @(posedge clk); #1;
        req_a[4 +: 4]  = 4'd5;
        req_b[4 +: 4]  = 4'd3;
        req_cin[1]     = 1'b1;
        req_a[12 +: 4] = 4'd1;
        req_b[12 +: 4] = 4'd1;
        req_cin[3]     = 1'b0;
        req_valid      = 4'b1010;
        @(negedge clk);
        check("fresh_ready", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("fresh_valid", rsp_valid, 1);
        check("fresh_product", rsp_product, 4'b0000);
        check("fresh_carry", rsp_carry_out, 1);
        check("fresh_id", rsp_id, 1);
        @(negedge clk);
        check("fresh_done", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
